// File: rtl/note_synth.sv
// Square-wave note generator: plays one latched pitch for a latched duration,
// then pulses done. A start/busy/done handshake lets notes chain back-to-back.
module note_synth #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_CYCLES = 6_250_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_start,
    input  logic [2:0] i_octave,
    input  logic [2:0] i_note,
    input  logic [3:0] i_length,
    input  logic [2:0] i_tempo,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_buzzer
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t      r_state;
    logic [23:0] r_phase;
    logic [31:0] r_tick;
    logic [23:0] r_half;
    logic [31:0] r_dur;
    logic        r_rest;
    logic        r_busy;
    logic        r_done;
    logic        r_buzzer;

    state_t      w_next;
    logic [23:0] w_base;
    logic [23:0] w_half_in;
    logic [31:0] w_dur_in;
    logic [23:0] w_phase_nx;
    logic [31:0] w_tick_nx;
    logic        w_buzz_nx;
    logic        w_accept;
    logic        w_wrap;

    // Octave-4 half-periods, resolved at elaboration.
    always_comb begin
        case (i_note)
            3'd1:    w_base = 24'(CLK_HZ / (2 * 262));
            3'd2:    w_base = 24'(CLK_HZ / (2 * 294));
            3'd3:    w_base = 24'(CLK_HZ / (2 * 330));
            3'd4:    w_base = 24'(CLK_HZ / (2 * 349));
            3'd5:    w_base = 24'(CLK_HZ / (2 * 392));
            3'd6:    w_base = 24'(CLK_HZ / (2 * 440));
            3'd7:    w_base = 24'(CLK_HZ / (2 * 494));
            default: w_base = 24'd0;
        endcase
    end

    assign w_half_in = (i_octave < 3'd4) ? (w_base << (3'd4 - i_octave))
                                         : (w_base >> (i_octave - 3'd4));
    assign w_dur_in  = 32'(i_length) * (32'(i_tempo) + 32'd1) * 32'(TICK_CYCLES);
    assign w_wrap    = (r_phase == r_half - 24'd1);

    // DONE accepts a new start like IDLE so a sequencer can chain notes
    // with only the single silent DONE cycle between them.
    always_comb begin
        w_next     = r_state;
        w_phase_nx = r_phase;
        w_tick_nx  = r_tick;
        w_buzz_nx  = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (i_start) begin
                    w_accept   = 1'b1;
                    w_next     = (w_dur_in == 32'd0) ? S_DONE : S_PLAY;
                    w_phase_nx = 24'd0;
                    w_tick_nx  = 32'd0;
                end
            end
            S_PLAY: begin
                w_tick_nx  = r_tick + 32'd1;
                w_phase_nx = w_wrap ? 24'd0 : r_phase + 24'd1;
                w_buzz_nx  = (w_wrap && !r_rest) ? ~r_buzzer : r_buzzer;
                if (r_tick == r_dur - 32'd1) begin
                    w_next    = S_DONE;
                    w_buzz_nx = 1'b0;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (!i_en) begin
            w_next    = S_IDLE;
            w_buzz_nx = 1'b0;
            w_accept  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_phase  <= 24'd0;
            r_tick   <= 32'd0;
            r_half   <= 24'd0;
            r_dur    <= 32'd0;
            r_rest   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_phase  <= w_phase_nx;
            r_tick   <= w_tick_nx;
            r_buzzer <= w_buzz_nx;
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
            if (w_accept) begin
                r_half <= w_half_in;
                r_dur  <= w_dur_in;
                r_rest <= (i_note == 3'd0);
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_buzzer = r_buzzer;

endmodule

// File: tb/tb_note_synth.sv
// Scoreboard bench for note_synth: drivers push expected output transitions,
// a monitor pops and compares them as the DUT outputs change.
module tb_note_synth;

  localparam int CLK_HZ = 200_000;
  localparam int TICK   = 100;

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [2:0] octave, note, tempo;
  logic [3:0] length;
  logic       busy, done, buzzer;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Expected transitions per output: {edge index, new value}.
  logic [32:0] buz_q[$];
  logic [32:0] done_q[$];
  logic [32:0] busy_q[$];

  note_synth #(.CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start),
    .i_octave(octave), .i_note(note), .i_length(length), .i_tempo(tempo),
    .o_busy(busy), .o_done(done), .o_buzzer(buzzer)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: simulation exceeded cycle budget (cyc=%0d)", cyc);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int half_p(input int oct, input int nt);
    int f;
    int h;
    case (nt)
      1: f = 262;
      2: f = 294;
      3: f = 330;
      4: f = 349;
      5: f = 392;
      6: f = 440;
      default: f = 494;
    endcase
    h = CLK_HZ / (2 * f);
    if (oct < 4) h = h * (1 << (4 - oct));
    else         h = h / (1 << (oct - 4));
    return h;
  endfunction

  function automatic int dur_of(input int len, input int tmp);
    return len * (tmp + 1) * TICK;
  endfunction

  task automatic push_evt(input int kind, input int t, input logic v);
    logic [32:0] e;
    e = {32'(t), v};
    case (kind)
      0: buz_q.push_back(e);
      1: done_q.push_back(e);
      default: busy_q.push_back(e);
    endcase
  endtask

  // Expected output transitions of one note accepted at edge e0.
  task automatic model_note(input int e0, input int oct, input int nt, input int len,
                            input int tmp, input int abort_at, input bit chain_in,
                            input bit chain_out);
    int d;
    int end_t;
    int h;
    logic lvl;
    d = dur_of(len, tmp);
    end_t = (abort_at > 0) ? abort_at : d;
    if (!chain_in) push_evt(2, e0, 1'b1);
    lvl = 1'b0;
    if (nt != 0 && d > 0) begin
      h = half_p(oct, nt);
      for (int t = h; t < end_t; t += h) begin
        lvl = ~lvl;
        push_evt(0, e0 + t, lvl);
      end
      if (lvl) push_evt(0, e0 + end_t, 1'b0);
    end
    if (abort_at > 0) begin
      push_evt(2, e0 + end_t, 1'b0);
    end else begin
      push_evt(1, e0 + d, 1'b1);
      push_evt(1, e0 + d + 1, 1'b0);
      if (!chain_out) push_evt(2, e0 + d + 1, 1'b0);
    end
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_evt(input int kind, input logic v);
    logic [32:0] e;
    string nm;
    bit empty;
    nm = (kind == 0) ? "buzzer" : (kind == 1) ? "done" : "busy";
    empty = (kind == 0) ? (buz_q.size() == 0) : (kind == 1) ? (done_q.size() == 0)
                                                             : (busy_q.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL %s: unexpected change to %0b at cycle %0d, none expected", nm, v, cyc);
    end else begin
      case (kind)
        0: e = buz_q.pop_front();
        1: e = done_q.pop_front();
        default: e = busy_q.pop_front();
      endcase
      if (e !== {32'(cyc), v}) begin
        errors++;
        $display("FAIL %s: got %0b at cycle %0d, expected %0b at cycle %0d",
                 nm, v, cyc, e[0], e[32:1]);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic pb, pd, py;
    pb = 1'b0;
    pd = 1'b0;
    py = 1'b0;
    wait (mon_on);
    forever begin
      @(posedge clk);
      #1;
      if (buzzer !== pb) begin chk_evt(0, buzzer); pb = buzzer; end
      if (done   !== pd) begin chk_evt(1, done);   pd = done;   end
      if (busy   !== py) begin chk_evt(2, busy);   py = busy;   end
    end
  end

  // ---------------- driver ----------------
  // Plays one note; inputs change at falling edges. Returns at the falling
  // edge of the DONE cycle (or just after an abort has taken effect).
  task automatic play(input int oct, input int nt, input int len, input int tmp,
                      input int abort_at, input bit abort_rst,
                      input bit chain_in, input bit chain_out);
    int e0;
    int d;
    int rel;
    d = dur_of(len, tmp);
    if (!chain_in) @(negedge clk);
    en = 1'b1;
    start = 1'b1;
    octave = 3'(oct);
    note = 3'(nt);
    length = 4'(len);
    tempo = 3'(tmp);
    e0 = cyc + 1;
    model_note(e0, oct, nt, len, tmp, abort_at, chain_in, chain_out);
    forever begin
      @(negedge clk);
      rel = cyc + 1 - e0;
      if (abort_at > 0 && rel == abort_at) begin
        start = 1'b0;
        if (abort_rst) rst = 1'b1;
        else en = 1'b0;
      end else if (abort_at > 0 && rel == abort_at + 1) begin
        if (abort_rst) begin
          chk("rst_abort_busy", 32'(busy), 32'd0);
          chk("rst_abort_done", 32'(done), 32'd0);
          chk("rst_abort_buzzer", 32'(buzzer), 32'd0);
        end
        rst = 1'b0;
        en = 1'b1;
        return;
      end else if (abort_at == 0 && rel == d + 1) begin
        if (!chain_out) start = 1'b0;
        return;
      end else begin
        // Scramble held inputs and sprinkle ignored start pulses mid-note.
        octave = 3'($urandom_range(0, 7));
        note = 3'($urandom_range(0, 7));
        length = 4'($urandom_range(0, 15));
        tempo = 3'($urandom_range(0, 7));
        start = (rel < ((abort_at > 0) ? abort_at : d)) && ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit chain;
    bit chain_out;
    int oct, nt, len, tmp, d, ab;
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    octave = 3'd0;
    note = 3'd0;
    length = 4'd0;
    tempo = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_buzzer", 32'(buzzer), 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    play(4, 6, 8, 1, 0, 0, 0, 0);      // basic note, H=227
    play(5, 1, 4, 1, 0, 0, 0, 0);      // octave up
    play(0, 1, 15, 7, 0, 0, 0, 0);     // lowest octave, longest note
    play(7, 7, 2, 0, 0, 0, 0, 0);      // highest pitch
    play(4, 0, 3, 1, 0, 0, 0, 0);      // rest
    play(3, 2, 0, 5, 0, 0, 0, 0);      // zero length
    play(4, 3, 2, 1, 0, 0, 0, 1);      // back-to-back pair
    play(6, 5, 3, 0, 0, 0, 1, 0);
    play(4, 6, 8, 0, 400, 0, 0, 0);    // en drop mid-note
    play(5, 4, 6, 0, 333, 1, 0, 0);    // reset mid-note

    // en low with start in IDLE must not start anything.
    @(negedge clk);
    en = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_low_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    en = 1'b1;

    chain = 1'b0;
    for (int i = 0; i < 14; i++) begin
      oct = $urandom_range(0, 7);
      nt = $urandom_range(0, 7);
      len = $urandom_range(0, 5);
      tmp = $urandom_range(0, 3);
      if (chain && len == 0) len = 1;
      d = dur_of(len, tmp);
      ab = (d >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, d - 1) : 0;
      chain_out = (ab == 0) && (i < 13) && ($urandom_range(0, 1) == 1);
      play(oct, nt, len, tmp, ab, 1'($urandom_range(0, 1)), chain, chain_out);
      chain = chain_out;
    end

    repeat (5) @(negedge clk);
    chk("pending_buzzer", 32'(buz_q.size()), 32'd0);
    chk("pending_done", 32'(done_q.size()), 32'd0);
    chk("pending_busy", 32'(busy_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
